regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/dlx_regs_pkg.sv | 19 +
 rtl/regfile_rdport.sv | 48 ++++
 rtl/regfile_sb.sv | 107 ++++++++++
 3 files changed

// File: rtl/dlx_regs_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dlx_regs_pkg
// Description : Shared constants and types for the integer register file
//               with scoreboard (default widths, address/data typedefs).
// Revision    : 1.0 - initial release
//==============================================================================
package dlx_regs_pkg;

    // Default architectural data width and register count
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Register number and register value at the default configuration
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          reg_data_t;

endpackage : dlx_regs_pkg
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
//==============================================================================
// Module      : regfile_rdport
// Description : One combinational read port of the scoreboarded register
//               file: register select, register-0 zeroing and, when the
//               REGFILE_BYPASS_EN macro is defined, write-to-read forwarding.
// Revision    : 1.0 - initial release
//==============================================================================
module regfile_rdport
    import dlx_regs_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic [$clog2(NREGS)-1:0]   addr,
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                       wr_en,
    input  logic [$clog2(NREGS)-1:0]   wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       iss_en,
    input  logic [$clog2(NREGS)-1:0]   iss_addr,
`endif
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_busy
);

    // Select stored value and busy bit; forward a same-cycle writeback when
    // enabled; register 0 always reads as zero and never busy.
    always_comb begin
        rd_data = regs[addr];
        rd_busy = busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == addr)) begin
            rd_data = wr_data;
            // A concurrent issue to the same register re-marks it pending
            rd_busy = iss_en && (iss_addr == addr);
        end
`endif
        if (addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
//==============================================================================
// Module      : regfile_sb
// Description : Register file with per-register pending-write scoreboard.
//               NRD combinational read ports, one writeback port, one issue
//               port, and a registered count of busy registers. Register 0
//               is hard-wired to zero. Define REGFILE_BYPASS_EN to forward
//               same-cycle writeback data to the read ports.
// Revision    : 1.0 - initial release
//==============================================================================
module regfile_sb
    import dlx_regs_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0]            rd_data,
    output logic [NRD-1:0]                      rd_busy,
    input  logic                                wr_en,
    input  logic [$clog2(NREGS)-1:0]            wr_addr,
    input  logic [XLEN-1:0]                     wr_data,
    input  logic                                iss_en,
    input  logic [$clog2(NREGS)-1:0]            iss_addr,
    output logic [$clog2(NREGS+1)-1:0]          npend
);

    localparam int NPW = $clog2(NREGS+1);

    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0]           r_busy;
    logic [NPW-1:0]             r_npend;

    logic                       w_wr_ok;
    logic                       w_iss_ok;
    logic [NREGS-1:0]           w_busy_nxt;
    logic [NPW-1:0]             w_npend_nxt;

    assign w_wr_ok  = wr_en  && (wr_addr  != '0);
    assign w_iss_ok = iss_en && (iss_addr != '0);

    // Next scoreboard state: writeback clears, issue sets; issue applied last
    // so it wins on a same-register collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Population count of the next busy vector so npend tracks the bits
    // on the same edge.
    always_comb begin
        w_npend_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_npend_nxt = w_npend_nxt + NPW'(w_busy_nxt[i]);
        end
    end

    // Register storage, scoreboard and pending count; register 0 is never
    // written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs  <= '0;
            r_busy  <= '0;
            r_npend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy  <= w_busy_nxt;
            r_npend <= w_npend_nxt;
        end
    end

    assign npend = r_npend;

    generate
        for (genvar g = 0; g < NRD; g++) begin : g_rdport
            regfile_rdport #(
                .XLEN     (XLEN),
                .NREGS    (NREGS)
            ) u_rdport (
                .addr     (rd_addr[g]),
                .regs     (r_regs),
                .busy     (r_busy),
`ifdef REGFILE_BYPASS_EN
                .wr_en    (w_wr_ok),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .iss_en   (w_iss_ok),
                .iss_addr (iss_addr),
`endif
                .rd_data  (rd_data[g]),
                .rd_busy  (rd_busy[g])
            );
        end
    endgenerate

endmodule : regfile_sb
`default_nettype wire
